// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline stall/flush sequencer.
//   - ctrl_state_t : sequencer state (RUN, MEM_WAIT, KILL)
//   - stage_ctrl_t : enable/flush pair for one pipeline register
//   - REG_ZERO     : architectural x0 index, never a hazard source
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    KILL     = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Bundle between the RV32I datapath and the stall/flush sequencer.
//   master : datapath side (drives hazard/handshake status, receives controls)
//   slave  : sequencer side (reads status, drives PC and stage controls)
//   Status : id_rs1/id_rs2/id_use_rs1/id_use_rs2, ex_rd/ex_mem_read/ex_redirect,
//            imem_valid/imem_busy, mem_dreq/dmem_ready
//   Control: pc_en/pc_sel and en/flush for IF_ID, ID_EX, EX_MEM, MEM_WB
interface pipeline_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_redirect;
  logic       imem_valid;
  logic       imem_busy;
  logic       mem_dreq;
  logic       dmem_ready;

  logic       pc_en;
  logic       pc_sel;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       ex_mem_flush;
  logic       mem_wb_en;
  logic       mem_wb_flush;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, imem_valid, imem_busy, mem_dreq, dmem_ready,
    input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, imem_valid, imem_busy, mem_dreq, dmem_ready,
    output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush
  );

endinterface

// File: rtl/pipeline_ctrl_counter.sv
// ctrl_event_counter
//   Free-running event counter, wraps modulo 2^W.
//   clk, reset_n (async active-low clear), inc (count this cycle), count (value)
module ctrl_event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Stall/flush sequencer for the 5-stage RV32I pipeline. Resolves, in priority
//   order, data-memory freeze, EX redirect, load-use bubble and fetch wait, and
//   discards fetches that were in flight when a redirect was taken.
//   clk, reset_n        : clock, async active-low reset
//   bus (slave)         : hazard/handshake status in, PC and stage controls out
//   stall_cnt           : cycles with pc_en=0 (outside reset)
//   flush_cnt           : redirects applied
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  pipeline_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state_q, state_d;
  ctrl_state_t eff_state;
  logic        ret_kill_q, ret_kill_d;

  logic        freeze;
  logic        rs1_hit, rs2_hit, load_use;

  stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
  logic        pc_en_c, pc_sel_c;

  assign freeze   = bus.mem_dreq & ~bus.dmem_ready;
  assign rs1_hit  = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit  = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
  assign load_use = bus.ex_mem_read & (bus.ex_rd != REG_ZERO) & (rs1_hit | rs2_hit);

  // On the cycle a freeze releases, behave as the state it interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? (ret_kill_q ? KILL : RUN) : state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      ret_kill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_kill_q <= ret_kill_d;
    end
  end

  always_comb begin
    state_d    = eff_state;
    ret_kill_d = ret_kill_q;
    if (freeze) begin
      state_d = MEM_WAIT;
      // Capture the interrupted state only on entry; a long freeze holds it.
      if (state_q != MEM_WAIT) begin
        ret_kill_d = (state_q == KILL);
      end
    end else if (bus.ex_redirect) begin
      // A fetch still outstanding belongs to the old path and must be dropped.
      state_d = (bus.imem_busy & ~bus.imem_valid) ? KILL : RUN;
    end else if ((eff_state == KILL) && bus.imem_valid) begin
      state_d = RUN;
    end
  end

  always_comb begin
    pc_en_c  = 1'b0;
    pc_sel_c = 1'b0;
    if_id_c  = '0;
    id_ex_c  = '0;
    ex_mem_c = '0;
    mem_wb_c = '0;
    if (reset_n && !freeze) begin
      ex_mem_c.en = 1'b1;
      mem_wb_c.en = 1'b1;
      id_ex_c.en  = 1'b1;
      if (bus.ex_redirect) begin
        pc_en_c        = 1'b1;
        pc_sel_c       = 1'b1;
        if_id_c.en     = 1'b1;
        if_id_c.flush  = 1'b1;
        id_ex_c.flush  = 1'b1;
      end else if (load_use) begin
        // Hold IF_ID and the PC, inject one bubble into ID_EX.
        id_ex_c.flush = 1'b1;
      end else begin
        if_id_c.en = 1'b1;
        if ((eff_state == KILL) || !bus.imem_valid) begin
          if_id_c.flush = 1'b1;
        end else begin
          pc_en_c = 1'b1;
        end
      end
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.if_id_en     = if_id_c.en;
  assign bus.if_id_flush  = if_id_c.flush;
  assign bus.id_ex_en     = id_ex_c.en;
  assign bus.id_ex_flush  = id_ex_c.flush;
  assign bus.ex_mem_en    = ex_mem_c.en;
  assign bus.ex_mem_flush = ex_mem_c.flush;
  assign bus.mem_wb_en    = mem_wb_c.en;
  assign bus.mem_wb_flush = mem_wb_c.flush;

  ctrl_event_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (reset_n & ~pc_en_c),
    .count   (stall_cnt)
  );

  // pc_sel is high exactly on cycles where a redirect is applied.
  ctrl_event_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (pc_sel_c),
    .count   (flush_cnt)
  );

endmodule
